// File: rtl/pito_pkg.sv
// Shared types and constants for the pito program loader.
package pito_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StHoldPre  = 3'd1,
        StLoad     = 3'd2,
        StHoldPost = 3'd3,
        StDone     = 3'd4
    } pito_ld_state_e;

    // Target memory select encodings for mode_i; 2'b00 is illegal.
    localparam logic [1:0] PITO_LD_IMEM = 2'b01;
    localparam logic [1:0] PITO_LD_DMEM = 2'b10;
    localparam logic [1:0] PITO_LD_BOTH = 2'b11;

    // Default number of core-reset cycles around the write burst.
    localparam int unsigned PITO_HOLD_CYC = 4;

endpackage

// File: rtl/pito_prog_loader.sv
// Streams a program image into imem and/or dmem while holding the core in reset,
// then releases the core after a fixed guard interval.
module pito_prog_loader
    import pito_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned HOLD_CYC   = PITO_HOLD_CYC
) (
    input  logic                          pito_io_clk,
    input  logic                          pito_io_rst_n,
    // Command
    input  logic                          start_i,
    input  logic [1:0]                    mode_i,
    input  logic [31:0]                   base_i,
    input  logic [31:0]                   count_i,
    // Stream
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [DATA_W-1:0]             s_data_i,
    input  logic                          s_last_i,
    // Memories
    output logic                          imem_w_en_o,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
    output logic [DATA_W-1:0]             imem_data_o,
    output logic                          dmem_w_en_o,
    output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr_o,
    output logic [DATA_W-1:0]             dmem_data_o,
    // Status
    output logic                          core_rst_n_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [DATA_W-1:0]             csum_o
);

    localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);
    localparam int unsigned DmemAw = $clog2(DMEM_DEPTH);
    localparam int unsigned HoldW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);

    pito_ld_state_e r_state, w_state_d;

    logic [1:0]        r_mode;
    logic [31:0]       r_count;
    logic [31:0]       r_idx;
    logic [ImemAw-1:0] r_icur;
    logic [DmemAw-1:0] r_dcur;
    logic [HoldW-1:0]  r_hold;
    logic              r_imem_we;
    logic              r_dmem_we;
    logic [ImemAw-1:0] r_imem_addr;
    logic [DmemAw-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_csum;
    logic              r_err;
    logic              r_core_rst_n;

    logic [32:0] w_end;
    logic        w_illegal;
    logic        w_go;
    logic        w_bad_cmd;
    logic        w_accept;
    logic        w_final;
    logic        w_hold_wrap;
    logic        w_sel_imem;
    logic        w_sel_dmem;

    // Command legality: end address checked at 33 bits so base+count cannot wrap.
    assign w_end     = {1'b0, base_i} + {1'b0, count_i};
    assign w_illegal = (mode_i == 2'b00)
                    || (((mode_i == PITO_LD_IMEM) || (mode_i == PITO_LD_BOTH))
                        && (w_end > 33'(IMEM_DEPTH)))
                    || (((mode_i == PITO_LD_DMEM) || (mode_i == PITO_LD_BOTH))
                        && (w_end > 33'(DMEM_DEPTH)));

    assign w_sel_imem  = (r_mode == PITO_LD_IMEM) || (r_mode == PITO_LD_BOTH);
    assign w_sel_dmem  = (r_mode == PITO_LD_DMEM) || (r_mode == PITO_LD_BOTH);
    assign w_final     = (r_idx == r_count - 32'd1);
    assign w_hold_wrap = (r_hold == HoldLast);

    // State register.
    always_ff @(posedge pito_io_clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_d = r_state;
        w_go      = 1'b0;
        w_bad_cmd = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    if (w_illegal) begin
                        w_bad_cmd = 1'b1;
                    end else begin
                        w_go      = 1'b1;
                        w_state_d = StHoldPre;
                    end
                end
            end
            StHoldPre: begin
                if (w_hold_wrap) begin
                    w_state_d = (r_count == 32'd0) ? StHoldPost : StLoad;
                end
            end
            StLoad: begin
                if (s_valid_i) begin
                    w_accept = 1'b1;
                    if (w_final) begin
                        w_state_d = StHoldPost;
                    end else if (s_last_i) begin
                        // Early end of stream: abandon the load, core stays in reset.
                        w_state_d = StIdle;
                    end
                end
            end
            StHoldPost: begin
                if (w_hold_wrap) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Datapath: command latch, write pipeline, checksum, error and core reset.
    always_ff @(posedge pito_io_clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            r_mode       <= 2'b00;
            r_count      <= '0;
            r_idx        <= '0;
            r_icur       <= '0;
            r_dcur       <= '0;
            r_hold       <= '0;
            r_imem_we    <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_dmem_addr  <= '0;
            r_wdata      <= '0;
            r_csum       <= '0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_imem_we <= w_accept && w_sel_imem;
            r_dmem_we <= w_accept && w_sel_dmem;

            if (r_state == StHoldPre || r_state == StHoldPost) begin
                r_hold <= w_hold_wrap ? '0 : r_hold + HoldW'(1);
            end else begin
                r_hold <= '0;
            end

            if (w_go) begin
                r_mode       <= mode_i;
                r_count      <= count_i;
                r_idx        <= '0;
                r_icur       <= base_i[ImemAw-1:0];
                r_dcur       <= base_i[DmemAw-1:0];
                r_csum       <= '0;
                r_err        <= 1'b0;
                r_core_rst_n <= 1'b0;
            end

            if (w_bad_cmd) begin
                r_csum <= '0;
                r_err  <= 1'b1;
            end

            if (w_accept) begin
                r_idx       <= r_idx + 32'd1;
                r_icur      <= r_icur + ImemAw'(1);
                r_dcur      <= r_dcur + DmemAw'(1);
                r_imem_addr <= r_icur;
                r_dmem_addr <= r_dcur;
                r_wdata     <= s_data_i;
                r_csum      <= r_csum + s_data_i;
                // last must coincide exactly with the count-th word.
                if (w_final != s_last_i) begin
                    r_err <= 1'b1;
                end
            end

            if (w_state_d == StDone) begin
                r_core_rst_n <= 1'b1;
            end
        end
    end

    assign s_ready_o    = (r_state == StLoad);
    assign busy_o       = (r_state != StIdle);
    assign done_o       = (r_state == StDone);
    assign imem_w_en_o  = r_imem_we;
    assign dmem_w_en_o  = r_dmem_we;
    assign imem_addr_o  = r_imem_addr;
    assign dmem_addr_o  = r_dmem_addr;
    assign imem_data_o  = r_wdata;
    assign dmem_data_o  = r_wdata;
    assign csum_o       = r_csum;
    assign err_o        = r_err;
    assign core_rst_n_o = r_core_rst_n;

endmodule

// File: tb/tb_pito_prog_loader.sv
// Scoreboard bench for pito_prog_loader: expected writes are queued as words are
// accepted and checked when the memory write strobes appear.
module tb_pito_prog_loader;

    localparam int unsigned DataW = 32;
    localparam int unsigned Hold  = 4;

    typedef struct {
        logic        im;
        logic        dm;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [1:0]       mode_i;
    logic [31:0]      base_i;
    logic [31:0]      count_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [DataW-1:0] s_data_i;
    logic             s_last_i;
    logic             imem_w_en_o;
    logic [9:0]       imem_addr_o;
    logic [DataW-1:0] imem_data_o;
    logic             dmem_w_en_o;
    logic [9:0]       dmem_addr_o;
    logic [DataW-1:0] dmem_data_o;
    logic             core_rst_n_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [DataW-1:0] csum_o;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    int          done_cyc  = 0;
    int          done_cnt  = 0;
    int          imem_wr   = 0;
    int          dmem_wr   = 0;
    logic [31:0] exp_csum  = '0;
    exp_t        exp_q[$];
    int          wr_cyc[$];

    pito_prog_loader #(
        .DATA_W     (DataW),
        .IMEM_DEPTH (1024),
        .DMEM_DEPTH (1024),
        .HOLD_CYC   (Hold)
    ) u_dut (
        .pito_io_clk   (clk),
        .pito_io_rst_n (rst_n),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .base_i        (base_i),
        .count_i       (count_i),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data_i),
        .s_last_i      (s_last_i),
        .imem_w_en_o   (imem_w_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_data_o   (imem_data_o),
        .dmem_w_en_o   (dmem_w_en_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_data_o   (dmem_data_o),
        .core_rst_n_o  (core_rst_n_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .csum_o        (csum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            check("core_rst_in_done", 64'(core_rst_n_o), 64'd1);
        end
        if (imem_w_en_o || dmem_w_en_o) begin
            wr_cyc.push_back(cyc);
            if (imem_w_en_o) imem_wr++;
            if (dmem_w_en_o) dmem_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                exp_csum = exp_csum + e.data;
                check("imem_we", 64'(imem_w_en_o), 64'(e.im));
                check("dmem_we", 64'(dmem_w_en_o), 64'(e.dm));
                if (e.im) begin
                    check("imem_addr", 64'(imem_addr_o), 64'(e.addr[9:0]));
                    check("imem_data", 64'(imem_data_o), 64'(e.data));
                end
                if (e.dm) begin
                    check("dmem_addr", 64'(dmem_addr_o), 64'(e.addr[9:0]));
                    check("dmem_data", 64'(dmem_data_o), 64'(e.data));
                end
                check("csum_on_write", 64'(csum_o), 64'(exp_csum));
            end
        end
    end

    task automatic run_cmd(input logic [1:0] m, input logic [31:0] b, input logic [31:0] c);
        imem_wr  = 0;
        dmem_wr  = 0;
        done_cnt = 0;
        exp_csum = '0;
        wr_cyc.delete();
        mode_i   = m;
        base_i   = b;
        count_i  = c;
        start_i  = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // Offer one word, wait (bounded) for ready, queue the expected write.
    task automatic send_word(input logic [31:0] d, input logic last, input logic im,
                             input logic dm, input logic [31:0] addr);
        int n = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        while (!s_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_o) check("ready_timeout", 64'd0, 64'd1);
        else exp_q.push_back('{im, dm, addr, d});
        @(negedge clk);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check(tag, 64'd1, 64'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"},  64'(s_ready_o),    64'd0);
        check({tag, "_iwe"},    64'(imem_w_en_o),  64'd0);
        check({tag, "_dwe"},    64'(dmem_w_en_o),  64'd0);
        check({tag, "_busy"},   64'(busy_o),       64'd0);
        check({tag, "_done"},   64'(done_o),       64'd0);
        check({tag, "_err"},    64'(err_o),        64'd0);
        check({tag, "_csum"},   64'(csum_o),       64'd0);
        check({tag, "_iaddr"},  64'(imem_addr_o),  64'd0);
        check({tag, "_daddr"},  64'(dmem_addr_o),  64'd0);
        check({tag, "_idata"},  64'(imem_data_o),  64'd0);
        check({tag, "_ddata"},  64'(dmem_data_o),  64'd0);
        check({tag, "_corer"},  64'(core_rst_n_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s1_words[4];
        logic [31:0] s1_sum;
        logic [31:0] w;
        s1_words = '{32'h13, 32'h93, 32'h113, 32'h193};

        rst_n = 1'b0; start_i = 1'b0; mode_i = 2'b00; base_i = '0; count_i = '0;
        s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Imem load, back-to-back words.
        run_cmd(PITO_LD_IMEM_T(), 32'd0, 32'd4);
        s1_sum = '0;
        for (int i = 0; i < 4; i++) begin
            s1_sum = s1_sum + s1_words[i];
            send_word(s1_words[i], (i == 3), 1'b1, 1'b0, 32'(i));
        end
        wait_idle("s1_idle_timeout");
        repeat (3) @(negedge clk);
        check("s1_imem_writes", 64'(imem_wr), 64'd4);
        check("s1_dmem_writes", 64'(dmem_wr), 64'd0);
        check("s1_csum", 64'(csum_o), 64'(s1_sum));
        check("s1_done_cnt", 64'(done_cnt), 64'd1);
        check("s1_err", 64'(err_o), 64'd0);
        check("s1_core_rst_idle", 64'(core_rst_n_o), 64'd1);
        for (int i = 1; i < wr_cyc.size(); i++)
            check("s1_consecutive", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd1);

        // Mirrored load with a one-cycle stall between words.
        run_cmd(2'b11, 32'd8, 32'd2);
        w = $urandom;
        send_word(w, 1'b0, 1'b1, 1'b1, 32'd8);
        @(negedge clk);
        w = $urandom;
        send_word(w, 1'b1, 1'b1, 1'b1, 32'd9);
        wait_idle("s2_idle_timeout");
        check("s2_imem_writes", 64'(imem_wr), 64'd2);
        check("s2_dmem_writes", 64'(dmem_wr), 64'd2);
        check("s2_wr_gap", 64'(wr_cyc[1] - wr_cyc[0]), 64'd2);
        check("s2_err", 64'(err_o), 64'd0);

        // Early last on the 3rd of 5 words.
        run_cmd(PITO_LD_IMEM_T(), 32'd100, 32'd5);
        for (int i = 0; i < 3; i++)
            send_word(32'hA000 + 32'(i), (i == 2), 1'b1, 1'b0, 32'd100 + 32'(i));
        check("s4_busy_after_early_last", 64'(busy_o), 64'd0);
        repeat (5) @(negedge clk);
        check("s4_imem_writes", 64'(imem_wr), 64'd3);
        check("s4_err", 64'(err_o), 64'd1);
        check("s4_core_rst", 64'(core_rst_n_o), 64'd0);
        check("s4_done_cnt", 64'(done_cnt), 64'd0);
        check("s4_ready", 64'(s_ready_o), 64'd0);

        // Out-of-range dmem command.
        run_cmd(2'b10, 32'd1020, 32'd8);
        check("s3_err", 64'(err_o), 64'd1);
        check("s3_busy", 64'(busy_o), 64'd0);
        repeat (10) @(negedge clk);
        check("s3_writes", 64'(imem_wr + dmem_wr), 64'd0);
        check("s3_done_cnt", 64'(done_cnt), 64'd0);
        check("s3_core_rst", 64'(core_rst_n_o), 64'd0);

        // Zero-length load; a stray illegal start during the hold must be ignored.
        run_cmd(PITO_LD_IMEM_T(), 32'd0, 32'd0);
        check("s5_err_cleared", 64'(err_o), 64'd0);
        @(negedge clk);
        mode_i = 2'b00; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle("s5_idle_timeout");
        check("s5_done_latency", 64'(done_cyc - start_cyc), 64'(2 * Hold + 1));
        check("s5_done_cnt", 64'(done_cnt), 64'd1);
        check("s5_writes", 64'(imem_wr + dmem_wr), 64'd0);
        check("s5_err", 64'(err_o), 64'd0);

        // Reset after the 2nd word of a load ending exactly at the dmem top.
        run_cmd(2'b10, 32'd1018, 32'd6);
        send_word(32'h5555, 1'b0, 1'b0, 1'b1, 32'd1018);
        send_word(32'h6666, 1'b0, 1'b0, 1'b1, 32'd1019);
        s_valid_i = 1'b1;
        s_data_i  = 32'h7777;
        #2 rst_n = 1'b0;
        #1 check_reset_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        s_valid_i = 1'b0;
        check("s6_dmem_writes", 64'(dmem_wr), 64'd2);
        check("s6_busy", 64'(busy_o), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    function automatic logic [1:0] PITO_LD_IMEM_T();
        return 2'b01;
    endfunction

endmodule
